// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART frame transmitter.
// Optional feature macro: UART_TX_TWO_STOP_EN (two stop bits instead of one).

package uart_tx_pkg;

    // Payload width used when the instantiating module does not override it.
    localparam int unsigned DefaultDataWidth = 8;

    // Number of stop-bit cycles closing every frame.
`ifdef UART_TX_TWO_STOP_EN
    localparam int unsigned StopBits = 2;
`else
    localparam int unsigned StopBits = 1;
`endif

    // Frame sequencer states, binary encoded.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and data-bit counter for the UART frame transmitter.
// Loads the payload on acceptance, shifts it out LSB-first on request and flags the
// last data bit. The counter saturates at DataWidth-1 instead of wrapping.

module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int unsigned DataWidth = DefaultDataWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 shift_i,
    input  logic                 count_i,
    output logic                 bit_o,
    output logic                 ser_done_o
);

    localparam int unsigned CntW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(DataWidth - 1);

    logic [DataWidth-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    // Next-state of shift register and saturating bit counter.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = data_i;
            cnt_d   = '0;
        end else begin
            if (shift_i) begin
                shreg_d = shreg_q >> 1;
            end
            if (count_i && (cnt_q != LastIdx)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // bit_o is the next bit to put on the line; the caller decides when it is used.
    assign bit_o      = shreg_q[0];
    // Meaningful only while the sequencer is in the data phase.
    assign ser_done_o = (cnt_q == LastIdx);

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, LSB-first payload, optional parity, stop bit(s).
// TX_OUT and busy are registered and always describe the state being entered.
// Optional feature macro: UART_TX_TWO_STOP_EN (two stop bits instead of one).

module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  data_valid,
    input  logic                  PAR_EN,
    input  logic                  party_bit,
    output logic                  TX_OUT,
    output logic                  busy
);

    tx_state_e state_q, state_d;
    logic      tx_q, tx_d;
    logic      busy_q, busy_d;
    logic      par_en_q, par_en_d;

    logic      ser_load;
    logic      ser_shift;
    logic      ser_count;
    logic      ser_bit;
    logic      ser_done;

`ifdef UART_TX_TWO_STOP_EN
    logic      stop_cnt_q, stop_cnt_d;
`endif

    uart_tx_serializer #(
        .DataWidth (DATA_WIDTH)
    ) u_serializer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (ser_load),
        .data_i     (P_DATA),
        .shift_i    (ser_shift),
        .count_i    (ser_count),
        .bit_o      (ser_bit),
        .ser_done_o (ser_done)
    );

    // Next-state, serializer control and next line value.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        par_en_d  = par_en_q;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        ser_count = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        stop_cnt_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (data_valid) begin
                    ser_load = 1'b1;
                    par_en_d = PAR_EN;
                    state_d  = StStart;
                    tx_d     = 1'b0;
                end
            end
            StStart: begin
                // Put bit 0 on the line and pre-shift so bit 1 is ready next cycle.
                state_d   = StData;
                tx_d      = ser_bit;
                ser_shift = 1'b1;
            end
            StData: begin
                if (ser_done) begin
                    if (par_en_q) begin
                        state_d = StParity;
                        tx_d    = party_bit;
                    end else begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end
                end else begin
                    tx_d      = ser_bit;
                    ser_shift = 1'b1;
                    ser_count = 1'b1;
                end
            end
            StParity: begin
                state_d = StStop;
                tx_d    = 1'b1;
            end
            StStop: begin
                tx_d = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                if (stop_cnt_q == 1'(StopBits - 1)) begin
                    state_d = StIdle;
                end else begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
`else
                state_d = StIdle;
`endif
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // Sequencer and output registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            par_en_q <= par_en_d;
        end
    end

`ifdef UART_TX_TWO_STOP_EN
    // Stop-bit counter, cleared whenever the sequencer is outside STOP.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stop_cnt_q <= 1'b0;
        end else begin
            stop_cnt_q <= stop_cnt_d;
        end
    end
`endif

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule
